// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM port controller.
// State encoding, width defaults and RAM idle strobe levels.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    TURN    = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic WE_IDLE = 1'b0;
  localparam logic RE_IDLE = 1'b1;

endpackage

// File: rtl/ram_bus_driver.sv
// Tri-state driver for the shared RAM data bus.
// Ports: drive_en, wdata in; ram_data inout (Z when drive_en=0).
module ram_bus_driver
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] wdata,
  inout  wire  [DATA_W-1:0] ram_data
);

  assign ram_data = drive_en ? wdata : {DATA_W{1'bz}};

endmodule

// File: rtl/ram_port_controller.sv
// Valid/ready master for a 16x8 single-port RAM with shared data bus.
// Ports: clk, rst (sync, active-low); req_* in; rsp_* out;
// ram_we/ram_re/ram_addr out; ram_data inout.
// Build option RAM_CTRL_RDBACK_CHECK_EN: read back and verify writes.
module ram_port_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  // wait counter preload; RD_LAT is limited to 1..3
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              drive_en_q, drive_en_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
  logic              write_q, write_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_we_d    = ram_we_q;
    ram_re_d    = ram_re_q;
    ram_addr_d  = ram_addr_q;
    drive_en_d  = drive_en_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
    write_d     = write_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          ram_addr_d  = req_addr;
          wdata_d     = req_wdata;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
          write_d     = req_write;
          rsp_err_d   = 1'b0;
`endif
          if (req_write) begin
            state_d    = WRITE;
            ram_we_d   = 1'b1;
            ram_re_d   = 1'b0;
            drive_en_d = 1'b1;
          end else begin
            state_d  = RD_WAIT;
            ram_we_d = WE_IDLE;
            ram_re_d = 1'b1;
            cnt_d    = LAT_M1;
          end
        end
      end
      WRITE: begin
        // bus is released one full cycle before any read drives it
        state_d    = TURN;
        ram_we_d   = WE_IDLE;
        ram_re_d   = RE_IDLE;
        drive_en_d = 1'b0;
      end
      TURN: begin
`ifdef RAM_CTRL_RDBACK_CHECK_EN
        state_d = RD_WAIT;
        cnt_d   = LAT_M1;
`else
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
`endif
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_data;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
          rsp_err_d = write_q && (ram_data != wdata_q);
`endif
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= WE_IDLE;
      ram_re_q    <= RE_IDLE;
      ram_addr_q  <= '0;
      drive_en_q  <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
      write_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_addr_q  <= ram_addr_d;
      drive_en_q  <= drive_en_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
      write_q     <= write_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
`ifdef RAM_CTRL_RDBACK_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  ram_bus_driver #(
    .DATA_W(DATA_W)
  ) u_bus (
    .drive_en(drive_en_q),
    .wdata   (wdata_q),
    .ram_data(ram_data)
  );

endmodule

// File: doc/ram_port_controller.md
Name: ram_port_controller

Overview:
- Upstream master for the 16x8 single-port RAM (ram_single_port).
- Converts a valid/ready request stream and a valid/ready response stream into the RAM's we_in/re_in/addr_in strobes and its shared bidirectional 8-bit data bus.
- Owns bus direction and turnaround, so the RAM and the controller never both drive data.

Parameters:
- ADDR_W, 4, RAM address width (depth = 2**ADDR_W = 16).
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from the read-issue edge to the edge where ram_data is valid and sampled (1..3).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data or write acknowledge available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for write acknowledges.
- rsp_err  out  1  error flag; see Optional Feature.
- ram_we  out  1  drives RAM we_in.
- ram_re  out  1  drives RAM re_in.
- ram_addr  out  ADDR_W  drives RAM addr_in.
- ram_data  inout  DATA_W  shared RAM data bus.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_re=1 (RAM idle default), ram_addr=0, bus drive enable=0 (ram_data=Z).
- All outputs registered. ram_data = wdata_q only when drive_en=1, else Z. drive_en=1 only in WRITE.
- Reset asserted mid-operation aborts the transaction. No response is produced and the bus is released at that edge.
- FSM states: IDLE, WRITE, TURN, RD_WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch addr, wdata and write.
    - Write: go to WRITE.
    - Read: go to RD_WAIT with ram_re=1, ram_we=0, ram_addr=addr.
  - WRITE: one cycle. ram_we=1, ram_re=0, drive_en=1; the RAM captures on the next posedge. Then go to TURN.
  - TURN: one cycle. drive_en=0, ram_we=0, ram_re=1; guarantees a bus-release cycle before any later read. Then go to RESP with rsp_rdata=0.
  - RD_WAIT: count RD_LAT cycles holding ram_re=1 and ram_addr. On the final edge, sample ram_data into rsp_rdata, then go to RESP.
  - RESP: rsp_valid=1 with stable data until rsp_ready=1. On that edge go to IDLE; rsp_valid drops on the next cycle.
- req_ready is 0 outside IDLE: one outstanding transaction, no pipelining.
- Write latency: accept edge to rsp_valid = 3 cycles. Read latency: RD_LAT+1 cycles.
- Back-to-back requests: minimum spacing is 1 idle cycle (IDLE) after each response handshake.
- Address wraps naturally at ADDR_W bits. No range check.
- rsp_ready held high before rsp_valid has no effect. A request presented while busy is held off, not dropped.

Optional Feature:
- Macro: RAM_CTRL_RDBACK_CHECK_EN.
- Defined: each write runs WRITE, TURN, then RD_WAIT on the same address.
  - The sampled value is compared with wdata_q.
  - A mismatch sets rsp_err=1 on the write acknowledge.
  - rsp_rdata carries the read-back value.
  - Write latency becomes RD_LAT+3.
- Not defined: no read-back; rsp_err is tied 0.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum encoding (IDLE=0, WRITE=1, TURN=2, RD_WAIT=3, RESP=4), 3 bits;
  - ADDR_W and DATA_W defaults;
  - RAM idle strobe constants (WE_IDLE=0, RE_IDLE=1).
- One natural sub-module, ram_bus_driver: tri-state buffer with drive_en and wdata_q. It is kept separate so the bench can check drive_en independently.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 → req_ready=0, ram_we=0, ram_re=1, ram_data=Z, rsp_valid=0 throughout.
- Single write then read: write addr 4'h5 data 8'hA5, then read 4'h5 → ack rsp_rdata=0 after 3 cycles; read rsp_rdata=8'hA5 after RD_LAT+1 cycles; no cycle where ram_we=1 and drive_en=0.
- Full sweep: write i→addr i for i=0..15, then read 0..15 → responses 8'h00..8'h0F in order; req_addr 5'h10 truncated to addr 0.
- Response backpressure: read addr 3 (8'h3C) with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata=8'h3C stable; req_ready=0; completes one cycle after rsp_ready=1.
- Reset mid-operation: rst=0 during RD_WAIT → next cycle IDLE, rsp_valid=0, bus Z; a following read of the same address still returns stored data.
- RAM_CTRL_RDBACK_CHECK_EN: write 8'h5A with the RAM model forced to return 8'h00 → rsp_err=1, rsp_rdata=8'h00; with a normal model → rsp_err=0.
